// File: rtl/paddsb_arb.sv
// Two-requester round-robin front end for a saturating 4x4-bit packed adder.
// The result sits in a single-entry output register with valid/ready handshake.
module paddsb_arb (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_vld,
   input  logic [15:0] req0_rs,
   input  logic [15:0] req0_rt,
   output logic        req0_rdy,
   input  logic        req1_vld,
   input  logic [15:0] req1_rs,
   input  logic [15:0] req1_rt,
   output logic        req1_rdy,
   output logic        rsp_vld,
   output logic [15:0] rsp_rd,
   output logic        rsp_id,
   output logic [3:0]  rsp_sat,
   input  logic        rsp_rdy,
   output logic [7:0]  sat_cnt
);

   typedef enum logic {EMPTY, FULL} state_t;

   state_t      state;
   logic        ptr;
   logic        open;
   logic        gnt_id;
   logic        xfer;
   logic [15:0] sel_rs;
   logic [15:0] sel_rt;
   logic [15:0] sum_rd;
   logic [3:0]  sum_sat;

   assign open   = (state == EMPTY) || rsp_rdy;
   // Both valid: grant whoever did not win last; otherwise the lone requester.
   assign gnt_id = req1_vld & (~req0_vld | ~ptr);

   assign req0_rdy = rst_n & open & ~gnt_id;
   assign req1_rdy = rst_n & open & gnt_id;

   assign xfer = gnt_id ? (req1_vld & req1_rdy)
                        : (req0_vld & req0_rdy);

   assign sel_rs = gnt_id ? req1_rs : req0_rs;
   assign sel_rt = gnt_id ? req1_rt : req0_rt;

   assign rsp_vld = (state == FULL);

   always_comb begin
      logic [4:0] s;
      sum_rd  = '0;
      sum_sat = '0;
      s       = '0;
      for (int i = 0; i < 4; i++) begin
         s = {sel_rs[4*i+3], sel_rs[4*i +: 4]}
           + {sel_rt[4*i+3], sel_rt[4*i +: 4]};
         // Sign bits disagree only when the 5-bit sum left the 4-bit range.
         unique case ({s[4], s[3]})
            2'b01: begin
               sum_rd[4*i +: 4] = 4'h7;
               sum_sat[i]       = 1'b1;
            end
            2'b10: begin
               sum_rd[4*i +: 4] = 4'h8;
               sum_sat[i]       = 1'b1;
            end
            default: sum_rd[4*i +: 4] = s[3:0];
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= EMPTY;
         rsp_rd  <= 16'h0000;
         rsp_sat <= 4'h0;
         rsp_id  <= 1'b0;
         sat_cnt <= 8'h00;
         ptr     <= 1'b1;
      end else if (xfer) begin
         state   <= FULL;
         rsp_rd  <= sum_rd;
         rsp_sat <= sum_sat;
         rsp_id  <= gnt_id;
         ptr     <= gnt_id;
         if ((|sum_sat) && (sat_cnt != 8'hFF))
            sat_cnt <= sat_cnt + 8'h01;
      end else if ((state == FULL) && rsp_rdy) begin
         state <= EMPTY;
      end
   end

endmodule

// File: tb/tb_paddsb_arb.sv
// Scoreboard bench for paddsb_arb: a driver pushes hand-computed results on
// each accepted transfer, a monitor pops and compares on each consumed result.
module tb_paddsb_arb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_vld, req1_vld;
   logic [15:0] req0_rs, req0_rt, req1_rs, req1_rt;
   logic        req0_rdy, req1_rdy;
   logic        rsp_vld, rsp_id, rsp_rdy;
   logic [15:0] rsp_rd;
   logic [3:0]  rsp_sat;
   logic [7:0]  sat_cnt;

   logic [15:0] exp0_rd, exp1_rd;
   logic [3:0]  exp0_sat, exp1_sat;

   int total = 0;
   int bad   = 0;

   logic [20:0] sb_q[$];

   paddsb_arb dut (
      .clk(clk), .rst_n(rst_n),
      .req0_vld(req0_vld), .req0_rs(req0_rs), .req0_rt(req0_rt),
      .req0_rdy(req0_rdy),
      .req1_vld(req1_vld), .req1_rs(req1_rs), .req1_rt(req1_rt),
      .req1_rdy(req1_rdy),
      .rsp_vld(rsp_vld), .rsp_rd(rsp_rd), .rsp_id(rsp_id),
      .rsp_sat(rsp_sat), .rsp_rdy(rsp_rdy), .sat_cnt(sat_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // driver side of the scoreboard
   always @(negedge clk) begin
      if (rst_n) begin
         if (req0_vld && req0_rdy && req1_vld && req1_rdy)
            chk("one_grant", 1, 0);
         else if (req0_vld && req0_rdy)
            sb_q.push_back({1'b0, exp0_sat, exp0_rd});
         else if (req1_vld && req1_rdy)
            sb_q.push_back({1'b1, exp1_sat, exp1_rd});
      end
   end

   // monitor side of the scoreboard
   always @(negedge clk) begin
      logic [20:0] e;
      if (rst_n && rsp_vld && rsp_rdy) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_rsp", {11'h0, rsp_id, rsp_sat, rsp_rd}, 0);
         end else begin
            e = sb_q.pop_front();
            chk("rsp_rd", rsp_rd, e[15:0]);
            chk("rsp_sat", rsp_sat, e[19:16]);
            chk("rsp_id", rsp_id, e[20]);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive0(input logic [15:0] rs, rt, rd, input logic [3:0] sat);
      req0_vld = 1'b1; req0_rs = rs; req0_rt = rt;
      exp0_rd = rd; exp0_sat = sat;
   endtask

   task automatic drive1(input logic [15:0] rs, rt, rd, input logic [3:0] sat);
      req1_vld = 1'b1; req1_rs = rs; req1_rt = rt;
      exp1_rd = rd; exp1_sat = sat;
   endtask

   task automatic wait_xfer0();
      int n = 0;
      @(negedge clk);
      while (!req0_rdy && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) chk("timeout_rdy0", 0, 1);
      step();
   endtask

   initial begin
      rst_n = 1'b0;
      req0_vld = 1'b0; req1_vld = 1'b0;
      req0_rs = '0; req0_rt = '0; req1_rs = '0; req1_rt = '0;
      exp0_rd = '0; exp0_sat = '0; exp1_rd = '0; exp1_sat = '0;
      rsp_rdy = 1'b1;

      // reset state, with a request already pending
      drive0(16'h1234, 16'h2143, 16'h3377, 4'h0);
      repeat (2) step();
      chk("rst_vld", rsp_vld, 0);
      chk("rst_rd", rsp_rd, 16'h0000);
      chk("rst_sat", rsp_sat, 4'h0);
      chk("rst_id", rsp_id, 0);
      chk("rst_cnt", sat_cnt, 8'h00);
      chk("rst_rdy0", req0_rdy, 0);
      chk("rst_rdy1", req1_rdy, 0);
      rst_n = 1'b1;

      // single request accepted on the first edge after reset
      step();
      req0_vld = 1'b0;
      chk("single_vld", rsp_vld, 1);
      chk("single_rd", rsp_rd, 16'h3377);
      chk("single_cnt", sat_cnt, 8'h00);

      // saturation cases, one per cycle
      drive0(16'h7777, 16'h1111, 16'h7777, 4'hF);
      step();
      drive0(16'h8888, 16'h8888, 16'h8888, 4'hF);
      step();
      drive0(16'h7F00, 16'h1100, 16'h7000, 4'b1000);
      step();
      req0_vld = 1'b0;
      chk("sat_rd", rsp_rd, 16'h7000);
      chk("sat_cnt3", sat_cnt, 8'd3);
      step();

      // backpressure
      rsp_rdy = 1'b0;
      drive0(16'h1234, 16'h2143, 16'h3377, 4'h0);
      wait_xfer0();
      req0_vld = 1'b0;
      drive1(16'h0101, 16'h0202, 16'h0303, 4'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_rdy0", req0_rdy, 0);
         chk("bp_rdy1", req1_rdy, 0);
         chk("bp_vld", rsp_vld, 1);
         chk("bp_rd", rsp_rd, 16'h3377);
         chk("bp_id", rsp_id, 0);
         step();
      end
      rsp_rdy = 1'b1;
      @(negedge clk);
      chk("bp_rel_rdy1", req1_rdy, 1);
      step();
      req1_vld = 1'b0;
      chk("reload_vld", rsp_vld, 1);
      chk("reload_id", rsp_id, 1);
      chk("reload_rd", rsp_rd, 16'h0303);
      step();

      // reset while FULL
      rsp_rdy = 1'b0;
      drive0(16'h7777, 16'h1111, 16'h7777, 4'hF);
      wait_xfer0();
      req0_vld = 1'b0;
      chk("pre_rst_vld", rsp_vld, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_vld", rsp_vld, 0);
      chk("mid_rst_rd", rsp_rd, 16'h0000);
      chk("mid_rst_sat", rsp_sat, 4'h0);
      chk("mid_rst_cnt", sat_cnt, 8'h00);
      sb_q.delete();
      rsp_rdy = 1'b1;

      // contention from reset: 0,1,0,1
      drive0(16'h1111, 16'h1111, 16'h2222, 4'h0);
      drive1(16'h3333, 16'h1111, 16'h4444, 4'h0);
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("ct_rdy0", req0_rdy, (i % 2 == 0));
         chk("ct_rdy1", req1_rdy, (i % 2 == 1));
         if (i > 0) chk("ct_vld", rsp_vld, 1);
         step();
      end
      req0_vld = 1'b0;
      req1_vld = 1'b0;
      chk("ct_last_id", rsp_id, 1);
      step();

      // sat_cnt saturates at FF
      drive0(16'h7777, 16'h1111, 16'h7777, 4'hF);
      for (int i = 0; i < 260; i++) begin
         step();
         if (i == 253) chk("cnt_254", sat_cnt, 8'd254);
         if (i == 254) chk("cnt_255", sat_cnt, 8'hFF);
      end
      req0_vld = 1'b0;
      chk("cnt_hold", sat_cnt, 8'hFF);
      repeat (3) step();
      chk("sb_empty", sb_q.size(), 0);
      chk("idle_vld", rsp_vld, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
